// File: rtl/sdio_host_cmd_phy_pkg.sv
// Shared definitions for the SDIO host CMD-line PHY: frame geometry,
// response type encodings and FSM state encoding.
// Optional feature macro: SDIO_HOST_NCC_EN (adds the post-response NCC gap state).
package sdio_host_cmd_phy_pkg;

  typedef enum logic [1:0] {
    SDIO_H_RSP_NONE        = 2'd0,
    SDIO_H_RSP_SHORT       = 2'd1,
    SDIO_H_RSP_LONG        = 2'd2,
    SDIO_H_RSP_SHORT_NOCRC = 2'd3
  } sdio_h_rsp_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_TX_FRAME,
    ST_TX_CRC,
    ST_TX_END,
    ST_RX_WAIT,
    ST_RX_DATA,
    ST_RX_END,
    ST_DONE
`ifdef SDIO_HOST_NCC_EN
    , ST_NCC_GAP
`endif
  } sdio_h_state_e;

  localparam int SDIO_H_RSPS_TIMEOUT = 64;
  localparam int SDIO_H_NCC_CYCLES   = 8;

  // Command payload = start, direction, 6-bit index, 32-bit argument.
  localparam int          SDIO_H_TX_BITS   = 40;
  localparam logic [1:0]  SDIO_H_TX_PREFIX = 2'b01;
  // Longest response minus its end bit (start bit included).
  localparam int          SDIO_H_RX_BITS   = 135;

  // Bit counter terminal values (count of bits already handled in the cycle).
  localparam logic [7:0] SDIO_H_TX_LAST_CNT       = 8'd39;
  localparam logic [7:0] SDIO_H_CRC_LAST_CNT      = 8'd6;
  localparam logic [7:0] SDIO_H_SHORT_LAST_CNT    = 8'd46;
  localparam logic [7:0] SDIO_H_LONG_LAST_CNT     = 8'd134;
  localparam logic [7:0] SDIO_H_SHORT_CRC_END_CNT = 8'd39;
  localparam logic [7:0] SDIO_H_LONG_CRC_BEG_CNT  = 8'd8;
  localparam logic [7:0] SDIO_H_LONG_CRC_END_CNT  = 8'd127;

  // True when the response bit arriving after 'cnt' earlier bits is CRC-covered.
  // Short: bits [47:8]; long: bits [127:8] (start/dir/reserved excluded).
  function automatic logic sdio_h_rx_feeds_crc(input sdio_h_rsp_e rsp, input logic [7:0] cnt);
    if (rsp == SDIO_H_RSP_LONG)
      return (cnt >= SDIO_H_LONG_CRC_BEG_CNT) && (cnt <= SDIO_H_LONG_CRC_END_CNT);
    else
      return cnt <= SDIO_H_SHORT_CRC_END_CNT;
  endfunction

endpackage

// File: rtl/sdio_host_cmd_phy_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), MSB-first. Shared by command generation and
// response checking; clr has priority over hold.
module sdio_host_cmd_phy_crc7 (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       hold,
  input  logic       bit_in,
  output logic [6:0] crc
);

  logic fb;
  assign fb = bit_in ^ crc[6];

  // LFSR update, one data bit per enabled cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      crc <= 7'd0;
    else if (clr)
      crc <= 7'd0;
    else if (!hold)
      crc <= {crc[5:3], crc[2] ^ fb, crc[1:0], fb};
  end

endmodule

// File: rtl/sdio_host_cmd_phy.sv
// Host-side SD/SDIO CMD-line PHY: sends a 48-bit command with CRC7, then
// waits for and captures a 48/136-bit response with timeout and CRC check.
// Optional feature macro: SDIO_HOST_NCC_EN (enforce NCC_CYCLES idle gap after a response).
//
// state       | meaning
// ST_IDLE     | ready, waiting for cmd_stb
// ST_TX_FRAME | driving start/dir/index/argument (40 bits)
// ST_TX_CRC   | driving 7 CRC bits
// ST_TX_END   | driving end bit
// ST_RX_WAIT  | line released, looking for response start bit
// ST_RX_DATA  | shifting in response bits
// ST_RX_END   | sampling end bit, latching result
// ST_DONE     | done_stb cycle
// ST_NCC_GAP  | post-response idle gap (SDIO_HOST_NCC_EN only)
module sdio_host_cmd_phy
  import sdio_host_cmd_phy_pkg::*;
#(
  parameter int RSPS_TIMEOUT = SDIO_H_RSPS_TIMEOUT
`ifdef SDIO_HOST_NCC_EN
  , parameter int NCC_CYCLES = SDIO_H_NCC_CYCLES
`endif
) (
  input  logic         sdio_clk,
  input  logic         rst,
  input  logic         cmd_stb,
  input  logic [5:0]   cmd,
  input  logic [31:0]  cmd_arg,
  input  logic [1:0]   rsps_type,
  output logic         cmd_phy_idle,
  output logic         done_stb,
  output logic         crc_err,
  output logic         timeout_err,
  output logic [5:0]   rsps_idx,
  output logic [127:0] rsps,
  output logic         sdio_cmd_dir,
  output logic         sdio_cmd_out,
  input  logic         sdio_cmd_in
);

  localparam int            TW      = $clog2(RSPS_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(RSPS_TIMEOUT - 1);

  sdio_h_state_e             state, state_nx;
  sdio_h_rsp_e               type_q;
  logic [SDIO_H_TX_BITS-1:0] tx_sh;
  logic [SDIO_H_RX_BITS-1:0] rx_sh;
  logic [7:0]                bit_cnt;
  logic [TW-1:0]             to_cnt;
  logic                      crc_clr, crc_hold, crc_bit;
  logic [6:0]                crc;

  sdio_host_cmd_phy_crc7 u_crc7 (
    .clk    (sdio_clk),
    .rst    (rst),
    .clr    (crc_clr),
    .hold   (crc_hold),
    .bit_in (crc_bit),
    .crc    (crc)
  );

`ifdef SDIO_HOST_NCC_EN
  localparam int            GW       = $clog2(NCC_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(NCC_CYCLES - 1);
  logic [GW-1:0] gap_cnt;

  // Count cycles spent in the post-response gap
  always_ff @(posedge sdio_clk or posedge rst) begin
    if (rst)
      gap_cnt <= '0;
    else if (state == ST_NCC_GAP)
      gap_cnt <= gap_cnt + 1'b1;
    else
      gap_cnt <= '0;
  end
`endif

  // State register
  always_ff @(posedge sdio_clk or posedge rst) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= state_nx;
  end

  // Next state, pad drive, CRC control and handshake outputs
  always_comb begin
    state_nx     = state;
    cmd_phy_idle = 1'b0;
    done_stb     = 1'b0;
    sdio_cmd_dir = 1'b0;
    sdio_cmd_out = 1'b1;
    crc_clr      = 1'b0;
    crc_hold     = 1'b1;
    crc_bit      = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_phy_idle = 1'b1;
        crc_clr      = 1'b1;
        if (cmd_stb) state_nx = ST_TX_FRAME;
      end
      ST_TX_FRAME: begin
        sdio_cmd_dir = 1'b1;
        sdio_cmd_out = tx_sh[SDIO_H_TX_BITS-1];
        crc_hold     = 1'b0;
        crc_bit      = tx_sh[SDIO_H_TX_BITS-1];
        if (bit_cnt == SDIO_H_TX_LAST_CNT) state_nx = ST_TX_CRC;
      end
      ST_TX_CRC: begin
        sdio_cmd_dir = 1'b1;
        sdio_cmd_out = crc[3'd6 - bit_cnt[2:0]];
        if (bit_cnt == SDIO_H_CRC_LAST_CNT) state_nx = ST_TX_END;
      end
      ST_TX_END: begin
        sdio_cmd_dir = 1'b1;
        sdio_cmd_out = 1'b1;
        crc_clr      = 1'b1;
        state_nx     = ST_RX_WAIT;
      end
      ST_RX_WAIT: begin
        crc_bit = sdio_cmd_in;
        if (type_q == SDIO_H_RSP_NONE)
          state_nx = ST_DONE;
        else if (!sdio_cmd_in) begin
          // Start bit is CRC-covered only in short responses.
          crc_hold = (type_q == SDIO_H_RSP_LONG);
          state_nx = ST_RX_DATA;
        end else if (to_cnt == TO_LAST)
          state_nx = ST_DONE;
      end
      ST_RX_DATA: begin
        crc_bit  = sdio_cmd_in;
        crc_hold = !sdio_h_rx_feeds_crc(type_q, bit_cnt);
        if (type_q == SDIO_H_RSP_LONG) begin
          if (bit_cnt == SDIO_H_LONG_LAST_CNT) state_nx = ST_RX_END;
        end else begin
          if (bit_cnt == SDIO_H_SHORT_LAST_CNT) state_nx = ST_RX_END;
        end
      end
      ST_RX_END: state_nx = ST_DONE;
      ST_DONE: begin
        done_stb = 1'b1;
`ifdef SDIO_HOST_NCC_EN
        state_nx = ST_NCC_GAP;
`else
        state_nx = ST_IDLE;
`endif
      end
`ifdef SDIO_HOST_NCC_EN
      ST_NCC_GAP: if (gap_cnt == GAP_LAST) state_nx = ST_IDLE;
`endif
      default: state_nx = ST_IDLE;
    endcase
  end

  // Shift registers, counters and latched response/status
  always_ff @(posedge sdio_clk or posedge rst) begin
    if (rst) begin
      tx_sh       <= '0;
      rx_sh       <= '0;
      type_q      <= SDIO_H_RSP_NONE;
      bit_cnt     <= 8'd0;
      to_cnt      <= '0;
      crc_err     <= 1'b0;
      timeout_err <= 1'b0;
      rsps_idx    <= 6'd0;
      rsps        <= 128'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_stb) begin
            tx_sh   <= {SDIO_H_TX_PREFIX, cmd, cmd_arg};
            type_q  <= sdio_h_rsp_e'(rsps_type);
            bit_cnt <= 8'd0;
          end
        end
        ST_TX_FRAME: begin
          tx_sh   <= {tx_sh[SDIO_H_TX_BITS-2:0], 1'b0};
          bit_cnt <= (bit_cnt == SDIO_H_TX_LAST_CNT) ? 8'd0 : bit_cnt + 8'd1;
        end
        ST_TX_CRC: bit_cnt <= bit_cnt + 8'd1;
        ST_TX_END: begin
          bit_cnt <= 8'd0;
          to_cnt  <= '0;
        end
        ST_RX_WAIT: begin
          to_cnt <= to_cnt + 1'b1;
          if (type_q == SDIO_H_RSP_NONE) begin
            crc_err     <= 1'b0;
            timeout_err <= 1'b0;
          end else if (!sdio_cmd_in) begin
            rx_sh   <= {rx_sh[SDIO_H_RX_BITS-2:0], 1'b0};
            bit_cnt <= 8'd1;
          end else if (to_cnt == TO_LAST) begin
            crc_err     <= 1'b0;
            timeout_err <= 1'b1;
          end
        end
        ST_RX_DATA: begin
          rx_sh   <= {rx_sh[SDIO_H_RX_BITS-2:0], sdio_cmd_in};
          bit_cnt <= bit_cnt + 8'd1;
        end
        ST_RX_END: begin
          // rx_sh[k-1] holds response bit k; rx_sh[6:0] is the received CRC.
          crc_err     <= ((type_q != SDIO_H_RSP_SHORT_NOCRC) && (crc != rx_sh[6:0])) || !sdio_cmd_in;
          timeout_err <= 1'b0;
          if (type_q == SDIO_H_RSP_LONG) begin
            rsps_idx <= rx_sh[132:127];
            rsps     <= {rx_sh[126:0], 1'b0};
          end else begin
            rsps_idx <= rx_sh[44:39];
            rsps     <= {96'd0, rx_sh[38:7]};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sdio_host_cmd_phy.sv
// Self-checking bench for sdio_host_cmd_phy: directed commands, a device
// reply driver, and a scoreboard monitor checking TX frames and done results.
module tb_sdio_host_cmd_phy;

  logic         sdio_clk;
  logic         rst;
  logic         cmd_stb;
  logic [5:0]   cmd;
  logic [31:0]  cmd_arg;
  logic [1:0]   rsps_type;
  logic         cmd_phy_idle;
  logic         done_stb;
  logic         crc_err;
  logic         timeout_err;
  logic [5:0]   rsps_idx;
  logic [127:0] rsps;
  logic         sdio_cmd_dir;
  logic         sdio_cmd_out;
  logic         sdio_cmd_in;

  sdio_host_cmd_phy dut (
    .sdio_clk     (sdio_clk),
    .rst          (rst),
    .cmd_stb      (cmd_stb),
    .cmd          (cmd),
    .cmd_arg      (cmd_arg),
    .rsps_type    (rsps_type),
    .cmd_phy_idle (cmd_phy_idle),
    .done_stb     (done_stb),
    .crc_err      (crc_err),
    .timeout_err  (timeout_err),
    .rsps_idx     (rsps_idx),
    .rsps         (rsps),
    .sdio_cmd_dir (sdio_cmd_dir),
    .sdio_cmd_out (sdio_cmd_out),
    .sdio_cmd_in  (sdio_cmd_in)
  );

  typedef struct {
    logic         crc_err;
    logic         timeout_err;
    int           lat;      // cycles from dir release to done_stb; -1 = unchecked
    bit           chk_rsps;
    logic [5:0]   idx;
    logic [127:0] rsps;
  } exp_done_t;

  logic [47:0] exp_tx_q[$];
  exp_done_t   exp_done_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int dir_fall_cyc = 0;

  localparam logic [119:0] CID = 120'h035344534431364780123456780157;

  initial begin
    sdio_clk = 1'b0;
    forever #5 sdio_clk = ~sdio_clk;
  end

  initial forever begin
    @(posedge sdio_clk);
    cyc++;
  end

  task automatic check_vec(input string name, input logic [135:0] act, input logic [135:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [6:0] crc7_calc(input logic [127:0] d, input int n);
    logic [6:0] c;
    logic       fb;
    c = 7'd0;
    for (int i = n - 1; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic logic [47:0] cmd_frame(input logic [5:0] c, input logic [31:0] a);
    logic [127:0] p;
    p = {88'd0, 2'b01, c, a};
    return {p[39:0], crc7_calc(p, 40), 1'b1};
  endfunction

  // Scoreboard monitor: captures driven frames and checks every done_stb
  initial begin : monitor
    logic [47:0] tx_cap;
    int          tx_cnt;
    logic        prev_dir;
    logic        idle_pending;
    logic [47:0] e_tx;
    exp_done_t   e;
    tx_cap = '0; tx_cnt = 0; prev_dir = 1'b0; idle_pending = 1'b0;
    forever begin
      @(negedge sdio_clk);
      if (rst) begin
        tx_cnt = 0; tx_cap = '0; prev_dir = 1'b0; idle_pending = 1'b0;
      end else begin
        if (idle_pending) begin
`ifndef SDIO_HOST_NCC_EN
          check_int("idle_after_done", int'(cmd_phy_idle), 1);
`endif
          idle_pending = 1'b0;
        end
        if (sdio_cmd_dir) begin
          tx_cap = {tx_cap[46:0], sdio_cmd_out};
          tx_cnt++;
        end else if (prev_dir) begin
          dir_fall_cyc = cyc;
          check_int("tx_len", tx_cnt, 48);
          check_int("tx_expected", int'(exp_tx_q.size() != 0), 1);
          if (exp_tx_q.size() != 0) begin
            e_tx = exp_tx_q.pop_front();
            check_vec("tx_frame", {88'd0, tx_cap}, {88'd0, e_tx});
          end
          tx_cnt = 0;
        end
        prev_dir = sdio_cmd_dir;
        if (done_stb) begin
          check_int("done_expected", int'(exp_done_q.size() != 0), 1);
          check_int("idle_during_done", int'(cmd_phy_idle), 0);
          idle_pending = 1'b1;
          if (exp_done_q.size() != 0) begin
            e = exp_done_q.pop_front();
            check_int("crc_err", int'(crc_err), int'(e.crc_err));
            check_int("timeout_err", int'(timeout_err), int'(e.timeout_err));
            if (e.lat >= 0) check_int("done_latency", cyc - dir_fall_cyc, e.lat);
            if (e.chk_rsps) begin
              check_int("rsps_idx", int'(rsps_idx), int'(e.idx));
              check_vec("rsps", {8'd0, rsps}, {8'd0, e.rsps});
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge sdio_clk);
    #2;
  endtask

  task automatic wait_dir(input logic lvl, input int max);
    int n = 0;
    while (sdio_cmd_dir !== lvl && n < max) begin
      tick();
      n++;
    end
    check_int("wait_dir", int'(sdio_cmd_dir), int'(lvl));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (cmd_phy_idle !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    check_int("wait_idle", int'(cmd_phy_idle), 1);
  endtask

  task automatic issue(input logic [5:0] c, input logic [31:0] a, input logic [1:0] t);
    wait_idle();
    cmd = c; cmd_arg = a; rsps_type = t; cmd_stb = 1'b1;
    tick();
    cmd_stb = 1'b0;
  endtask

  task automatic push_done(input logic ce, input logic te, input int lat, input bit chk,
                           input logic [5:0] idx, input logic [127:0] r);
    exp_done_t e;
    e.crc_err = ce; e.timeout_err = te; e.lat = lat; e.chk_rsps = chk; e.idx = idx; e.rsps = r;
    exp_done_q.push_back(e);
  endtask

  // Device side: wait for the command to finish, then reply after 'dly' cycles
  task automatic send_reply(input logic [135:0] frame, input int nbits, input int dly);
    wait_dir(1'b1, 100);
    wait_dir(1'b0, 100);
    repeat (dly) tick();
    for (int i = nbits - 1; i >= 0; i--) begin
      sdio_cmd_in = frame[i];
      tick();
    end
    sdio_cmd_in = 1'b1;
  endtask

  task automatic watch(input int n, output int dirs, output int dones);
    dirs = 0; dones = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (sdio_cmd_dir) dirs++;
      if (done_stb) dones++;
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1);
  end

  initial begin : stimulus
    int dirs, dones, n;
    logic [6:0] cid_crc;
    rst = 1'b1; cmd_stb = 1'b0; cmd = '0; cmd_arg = '0; rsps_type = '0; sdio_cmd_in = 1'b1;
    #3;
    check_int("rst_idle", int'(cmd_phy_idle), 1);
    check_int("rst_done", int'(done_stb), 0);
    check_int("rst_crc_err", int'(crc_err), 0);
    check_int("rst_timeout_err", int'(timeout_err), 0);
    check_int("rst_rsps_idx", int'(rsps_idx), 0);
    check_vec("rst_rsps", {8'd0, rsps}, 136'd0);
    check_int("rst_dir", int'(sdio_cmd_dir), 0);
    check_int("rst_out", int'(sdio_cmd_out), 1);
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // CMD0, no response; cmd_stb during done_stb must be ignored
    exp_tx_q.push_back(48'h400000000095);
    push_done(1'b0, 1'b0, 1, 1'b0, 6'd0, 128'd0);
    issue(6'd0, 32'h0, 2'd0);
    wait_dir(1'b1, 10);
    wait_dir(1'b0, 100);
    tick();
    check_int("done_cycle_for_stb", int'(done_stb), 1);
    cmd = 6'd0; cmd_arg = 32'h0; rsps_type = 2'd0; cmd_stb = 1'b1;
    tick();
    cmd_stb = 1'b0;
    watch(6, dirs, dones);
    check_int("stb_on_done_ignored", dirs, 0);

    // CMD8, valid R7
    exp_tx_q.push_back(48'h48000001AA87);
    push_done(1'b0, 1'b0, -1, 1'b1, 6'd8, 128'h1AA);
    issue(6'd8, 32'h000001AA, 2'd1);
    send_reply({88'd0, 48'h08000001AA13}, 48, 5);

    // CMD8, corrupted reply CRC
    exp_tx_q.push_back(48'h48000001AA87);
    push_done(1'b1, 1'b0, -1, 1'b1, 6'd8, 128'h1AA);
    issue(6'd8, 32'h000001AA, 2'd1);
    send_reply({88'd0, 48'h08000001AA15}, 48, 5);

    // CMD5 type 3, no reply: timeout exactly RSPS_TIMEOUT cycles after release
    exp_tx_q.push_back(cmd_frame(6'd5, 32'h0));
    push_done(1'b0, 1'b1, 64, 1'b0, 6'd0, 128'd0);
    issue(6'd5, 32'h0, 2'd3);
    wait_dir(1'b1, 10);
    wait_dir(1'b0, 100);

    // Start bit at last allowed wait cycle is accepted
    exp_tx_q.push_back(48'h48000001AA87);
    push_done(1'b0, 1'b0, -1, 1'b1, 6'd8, 128'h1AA);
    issue(6'd8, 32'h000001AA, 2'd1);
    send_reply({88'd0, 48'h08000001AA13}, 48, 63);

    // One cycle later is a timeout
    exp_tx_q.push_back(48'h48000001AA87);
    push_done(1'b0, 1'b1, 64, 1'b0, 6'd0, 128'd0);
    issue(6'd8, 32'h000001AA, 2'd1);
    send_reply({88'd0, 48'h08000001AA13}, 48, 64);

    // Type 3 (R3/R4): CRC field ignored, end bit still checked
    exp_tx_q.push_back(cmd_frame(6'd5, 32'h00FF8000));
    push_done(1'b0, 1'b0, -1, 1'b1, 6'h3F, 128'h00FF8000);
    issue(6'd5, 32'h00FF8000, 2'd3);
    send_reply({88'd0, 48'h3F00FF8000FF}, 48, 2);

    exp_tx_q.push_back(cmd_frame(6'd5, 32'h00FF8000));
    push_done(1'b1, 1'b0, -1, 1'b1, 6'h3F, 128'h00FF8000);
    issue(6'd5, 32'h00FF8000, 2'd3);
    send_reply({88'd0, 48'h3F00FF8000FE}, 48, 2);

    // CMD2, long CID response
    cid_crc = crc7_calc({8'd0, CID}, 120);
    exp_tx_q.push_back(48'h42000000004D);
    push_done(1'b0, 1'b0, -1, 1'b1, 6'h3F, {CID, cid_crc, 1'b0});
    issue(6'd2, 32'h0, 2'd2);
    send_reply({2'b00, 6'h3F, CID, cid_crc, 1'b1}, 136, 3);

    // Reset mid-frame at TX bit 20
    issue(6'd0, 32'h0, 2'd0);
    wait_dir(1'b1, 10);
    repeat (20) tick();
    rst = 1'b1;
    #1;
    check_int("midrst_dir", int'(sdio_cmd_dir), 0);
    check_int("midrst_out", int'(sdio_cmd_out), 1);
    check_int("midrst_idle", int'(cmd_phy_idle), 1);
    check_int("midrst_done", int'(done_stb), 0);
    repeat (2) tick();
    rst = 1'b0;
    watch(6, dirs, dones);
    check_int("after_rst_dir", dirs, 0);
    check_int("after_rst_done", dones, 0);

    // Clean CMD0 after reset
    exp_tx_q.push_back(48'h400000000095);
    push_done(1'b0, 1'b0, 1, 1'b0, 6'd0, 128'd0);
    issue(6'd0, 32'h0, 2'd0);

    n = 0;
    while ((exp_done_q.size() != 0 || exp_tx_q.size() != 0) && n < 500) begin
      tick();
      n++;
    end
    repeat (3) tick();
    check_int("tx_queue_drained", exp_tx_q.size(), 0);
    check_int("done_queue_drained", exp_done_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
